// File: rtl/pcm_deserializer.sv
// pcm_deserializer: oversampling receiver for the 3-wire PCM link (bit clock, LR select, serial data).
// Define PCM_RX_I2S_DELAY_EN for I2S one-bit-delay framing; left-justified framing otherwise.
module pcm_deserializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_active_low,
    input  logic                  bit_clock_in,
    input  logic                  LR_select_in,
    input  logic                  serial_data_in,
    output logic [DATA_WIDTH-1:0] pcm_data_left,
    output logic [DATA_WIDTH-1:0] pcm_data_right,
    output logic                  pcm_data_valid,
    output logic                  frame_error,
    output logic                  locked
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {HUNT, SHIFT, WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_bclkSync, r_lrSync, r_sdataSync;
    logic                   r_bclkPrev, r_strike, r_lrSmp, r_sdataSmp, r_lrPrev;

    state_t                 r_state, w_stateNext;
    logic [CW-1:0]          r_count, w_countNext, w_countBase, w_countInc;
    logic [DATA_WIDTH-2:0]  r_shreg, w_shregNext;
    logic [DATA_WIDTH-1:0]  r_shadow, w_shadowNext;
    logic [DATA_WIDTH-1:0]  r_left, w_leftNext, r_right, w_rightNext;
    logic                   r_channel, w_channelNext, r_leftOk, w_leftOkNext;
    logic                   r_valid, w_validNext, r_error, w_errorNext, r_locked, w_lockedNext;
    logic                   w_lrEdge, w_start, w_shift;
    logic [DATA_WIDTH-1:0]  w_word;

    // All link inputs share the same synchronizer depth so data and LR stay aligned with the strike.
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_bclkSync  <= '0;
            r_lrSync    <= '0;
            r_sdataSync <= '0;
            r_bclkPrev  <= 1'b0;
            r_strike    <= 1'b0;
            r_lrSmp     <= 1'b0;
            r_sdataSmp  <= 1'b0;
        end else begin
            r_bclkSync  <= {r_bclkSync[SYNC_STAGES-2:0], bit_clock_in};
            r_lrSync    <= {r_lrSync[SYNC_STAGES-2:0], LR_select_in};
            r_sdataSync <= {r_sdataSync[SYNC_STAGES-2:0], serial_data_in};
            r_bclkPrev  <= r_bclkSync[SYNC_STAGES-1];
            r_strike    <= r_bclkSync[SYNC_STAGES-1] & ~r_bclkPrev;
            r_lrSmp     <= r_lrSync[SYNC_STAGES-1];
            r_sdataSmp  <= r_sdataSync[SYNC_STAGES-1];
        end
    end

    assign w_lrEdge = (r_lrSmp != r_lrPrev);
    assign w_word   = {r_shreg, r_sdataSmp};

    always_comb begin
        w_stateNext   = r_state;
        w_countNext   = r_count;
        w_countBase   = r_count;
        w_countInc    = '0;
        w_shregNext   = r_shreg;
        w_shadowNext  = r_shadow;
        w_channelNext = r_channel;
        w_leftOkNext  = r_leftOk;
        w_leftNext    = r_left;
        w_rightNext   = r_right;
        w_lockedNext  = r_locked;
        w_validNext   = 1'b0;
        w_errorNext   = 1'b0;
        w_start       = 1'b0;
        w_shift       = 1'b0;
        if (r_strike) begin
            case (r_state)
                SHIFT: begin
                    if (w_lrEdge) begin
                        w_start      = 1'b1;
                        w_errorNext  = 1'b1;
                        w_lockedNext = 1'b0;
                        w_leftOkNext = 1'b0;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                default: w_start = w_lrEdge;
            endcase
            if (w_start) begin
                w_stateNext   = SHIFT;
                w_channelNext = r_lrSmp;
                w_countBase   = '0;
                w_countNext   = '0;
`ifndef PCM_RX_I2S_DELAY_EN
                w_shift       = 1'b1;
`endif
            end
            // A full word either fills the left shadow or completes a stereo pair.
            if (w_shift) begin
                w_countInc  = w_countBase + CW'(1);
                w_shregNext = w_word[DATA_WIDTH-2:0];
                w_countNext = w_countInc;
                if (w_countInc == CW'(DATA_WIDTH)) begin
                    w_stateNext = WAIT;
                    w_countNext = '0;
                    if (!w_channelNext) begin
                        w_shadowNext = w_word;
                        w_leftOkNext = 1'b1;
                    end else if (w_leftOkNext) begin
                        w_leftNext   = r_shadow;
                        w_rightNext  = w_word;
                        w_validNext  = 1'b1;
                        w_lockedNext = 1'b1;
                        w_leftOkNext = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_state   <= HUNT;
            r_count   <= '0;
            r_shreg   <= '0;
            r_shadow  <= '0;
            r_channel <= 1'b0;
            r_leftOk  <= 1'b0;
            r_lrPrev  <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_shreg   <= w_shregNext;
            r_shadow  <= w_shadowNext;
            r_channel <= w_channelNext;
            r_leftOk  <= w_leftOkNext;
            if (r_strike) begin
                r_lrPrev <= r_lrSmp;
            end
            r_left    <= w_leftNext;
            r_right   <= w_rightNext;
            r_valid   <= w_validNext;
            r_error   <= w_errorNext;
            r_locked  <= w_lockedNext;
        end
    end

    assign pcm_data_left  = r_left;
    assign pcm_data_right = r_right;
    assign pcm_data_valid = r_valid;
    assign frame_error    = r_error;
    assign locked         = r_locked;
endmodule
